// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator
//   Sums NUM_TERMS results of the upstream WIDTH-bit ripple adder, each taken
//   as the unsigned operand {carry, sum}, into an ACC_W-bit running total.
//   The total is offered with a valid/ready handshake and a sticky overflow flag.
//
// Ports
//   clk, rst_n          clock (rising edge) / async active-low reset
//   sum_in, carry_in    adder result Y and carry-out Co
//   in_valid, in_ready  operand handshake (in_ready low while holding or clearing)
//   clear               synchronous abort: zero the accumulation, back to ACCUM
//   acc_out             running partial sum, final sum when out_valid
//   ovf                 sticky wrap-past-2^ACC_W flag for this accumulation
//   term_cnt            operands accepted in this accumulation
//   out_valid, out_ready result handshake
module adder_sum_accumulator #(
   parameter int WIDTH     = 5,
   parameter int NUM_TERMS = 4,
   parameter int ACC_W     = 8,
   localparam int CNT_W    = $clog2(NUM_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             carry_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             clear,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf,
   output logic [CNT_W-1:0] term_cnt,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]     state;
   logic           accept;
   logic           last;
   logic [ACC_W:0] sum_ext;

   // in_ready depends on clear only, so no other input reaches an output
   // combinationally.
   assign in_ready  = (state == ACCUM) && !clear;
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;
   assign last      = (term_cnt == CNT_W'(NUM_TERMS - 1));

   // One spare bit on top of the accumulator catches the wrap carry.
   assign sum_ext = {1'b0, acc_out} + (ACC_W + 1)'({carry_in, sum_in});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ACCUM;
         acc_out  <= '0;
         ovf      <= 1'b0;
         term_cnt <= '0;
      end else if (clear) begin
         state    <= ACCUM;
         acc_out  <= '0;
         ovf      <= 1'b0;
         term_cnt <= '0;
      end else if (state == HOLD) begin
         // Result is frozen until taken; the zeroing cycle is the bubble
         // before the next accumulation can start.
         if (out_ready) begin
            state    <= ACCUM;
            acc_out  <= '0;
            ovf      <= 1'b0;
            term_cnt <= '0;
         end
      end else if (accept) begin
         acc_out  <= sum_ext[ACC_W-1:0];
         ovf      <= ovf | sum_ext[ACC_W];
         term_cnt <= term_cnt + CNT_W'(1);
         if (last) state <= HOLD;
      end
   end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
module tb_adder_sum_accumulator;

   typedef struct {
      int acc;
      int ovf;
      int cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance A: defaults
   logic [4:0] a_sum = '0;
   logic       a_carry = 1'b0, a_in_valid = 1'b0, a_clear = 1'b0, a_out_ready = 1'b0;
   logic       a_in_ready, a_ovf, a_out_valid;
   logic [7:0] a_acc;
   logic [2:0] a_cnt;

   // instance B: ACC_W = 7 for the wrap case
   logic [4:0] b_sum = '0;
   logic       b_carry = 1'b0, b_in_valid = 1'b0, b_clear = 1'b0, b_out_ready = 1'b0;
   logic       b_in_ready, b_ovf, b_out_valid;
   logic [6:0] b_acc;
   logic [2:0] b_cnt;

   adder_sum_accumulator u_a (
      .clk(clk), .rst_n(rst_n), .sum_in(a_sum), .carry_in(a_carry),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .clear(a_clear),
      .acc_out(a_acc), .ovf(a_ovf), .term_cnt(a_cnt),
      .out_valid(a_out_valid), .out_ready(a_out_ready));

   adder_sum_accumulator #(.ACC_W(7)) u_b (
      .clk(clk), .rst_n(rst_n), .sum_in(b_sum), .carry_in(b_carry),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .clear(b_clear),
      .acc_out(b_acc), .ovf(b_ovf), .term_cnt(b_cnt),
      .out_valid(b_out_valid), .out_ready(b_out_ready));

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t qa[$];
   exp_t qb[$];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitors: compare each completed result handshake.
   always @(negedge clk) begin
      if (rst_n && a_out_valid && a_out_ready) begin
         if (qa.size() == 0) chk("a_unexpected_result", 1, 0);
         else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_sb_acc", int'(a_acc), e.acc);
            chk("a_sb_ovf", int'(a_ovf), e.ovf);
            chk("a_sb_cnt", int'(a_cnt), e.cnt);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) chk("b_unexpected_result", 1, 0);
         else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_sb_acc", int'(b_acc), e.acc);
            chk("b_sb_ovf", int'(b_ovf), e.ovf);
            chk("b_sb_cnt", int'(b_cnt), e.cnt);
         end
      end
   end

   // Drive A's operand for one clock; returns 1 time unit after the edge.
   task automatic a_drive(input int s, input int c, input int v);
      a_sum = 5'(s); a_carry = 1'(c); a_in_valid = 1'(v);
      @(posedge clk); #1;
   endtask

   task automatic b_drive(input int s, input int c, input int v);
      b_sum = 5'(s); b_carry = 1'(c); b_in_valid = 1'(v);
      @(posedge clk); #1;
   endtask

   task automatic a_state(input string tag, input int acc, input int ovf,
                          input int cnt, input int ov);
      chk({tag, "_acc"}, int'(a_acc), acc);
      chk({tag, "_ovf"}, int'(a_ovf), ovf);
      chk({tag, "_cnt"}, int'(a_cnt), cnt);
      chk({tag, "_out_valid"}, int'(a_out_valid), ov);
   endtask

   task automatic a_clear_now();
      a_in_valid = 1'b0; a_clear = 1'b1;
      @(posedge clk); #1;
      a_clear = 1'b0;
   endtask

   initial begin
      exp_t e;
      int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
      int cnt_exp[7] = '{1, 1, 1, 2, 2, 3, 4};
      int n_acc;

      // reset state
      #2;
      a_state("reset", 0, 0, 0, 0);
      chk("reset_in_ready", int'(a_in_ready), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 1: four beats, result held (out_ready low)
      a_drive(12, 0, 1); a_state("t1_b1", 12, 0, 1, 0);
      a_drive(20, 0, 1); a_state("t1_b2", 32, 0, 2, 0);
      a_drive(17, 0, 1); a_state("t1_b3", 49, 0, 3, 0);
      e = '{acc: 86, ovf: 0, cnt: 4}; qa.push_back(e);
      a_drive(5, 1, 1);  a_state("t1_b4", 86, 0, 4, 1);
      chk("t1_in_ready", int'(a_in_ready), 0);

      // 3: backpressure, beats ignored while holding
      for (int i = 0; i < 5; i++) begin
         a_drive(7, 0, 1);
         a_state("t3_hold", 86, 0, 4, 1);
         chk("t3_hold_in_ready", int'(a_in_ready), 0);
      end
      a_out_ready = 1'b1;
      a_drive(7, 0, 1);
      a_out_ready = 1'b0;
      a_state("t3_after_hs", 0, 0, 0, 0);
      chk("t3_bubble_in_ready", int'(a_in_ready), 1);
      a_drive(7, 0, 1);
      a_state("t3_reload", 7, 0, 1, 0);
      a_clear_now();
      a_state("t3_cleared", 0, 0, 0, 0);

      // 4: gapped input, operand 10
      n_acc = 0;
      for (int i = 0; i < 7; i++) begin
         if (pat[i] == 1) n_acc += 10;
         if (i == 6) begin
            e = '{acc: 40, ovf: 0, cnt: 4}; qa.push_back(e);
         end
         a_drive(10, 0, pat[i]);
         chk("t4_cnt", int'(a_cnt), cnt_exp[i]);
         chk("t4_acc", int'(a_acc), n_acc);
         chk("t4_out_valid", int'(a_out_valid), (i == 6) ? 1 : 0);
      end
      a_out_ready = 1'b1;
      a_drive(0, 0, 0);
      a_out_ready = 1'b0;
      a_state("t4_after_hs", 0, 0, 0, 0);

      // 5: clear with an operand presented the same cycle
      a_drive(12, 0, 1);
      a_drive(20, 0, 1);
      a_state("t5_pre", 32, 0, 2, 0);
      a_sum = 5'd9; a_carry = 1'b0; a_in_valid = 1'b1; a_clear = 1'b1;
      #1;
      chk("t5_in_ready_clear", int'(a_in_ready), 0);
      @(posedge clk); #1;
      a_clear = 1'b0; a_in_valid = 1'b0;
      a_state("t5_post", 0, 0, 0, 0);

      // 6: async reset while holding a result
      a_drive(12, 0, 1);
      a_drive(20, 0, 1);
      a_drive(17, 0, 1);
      a_drive(5, 1, 1);
      a_in_valid = 1'b0;
      a_state("t6_hold", 86, 0, 4, 1);
      #2;
      rst_n = 1'b0;
      #1;
      a_state("t6_async", 0, 0, 0, 0);
      @(posedge clk); #1;
      a_state("t6_in_reset", 0, 0, 0, 0);
      rst_n = 1'b1;
      a_drive(10, 0, 1);
      a_state("t6_resume", 10, 0, 1, 0);
      a_clear_now();

      // 2: ACC_W=7 wrap, ovf sticky, handshake releases it
      b_out_ready = 1'b1;
      b_drive(31, 1, 1);
      chk("t2_b1_acc", int'(b_acc), 63);  chk("t2_b1_ovf", int'(b_ovf), 0);
      b_drive(31, 1, 1);
      chk("t2_b2_acc", int'(b_acc), 126); chk("t2_b2_ovf", int'(b_ovf), 0);
      b_drive(31, 1, 1);
      chk("t2_b3_acc", int'(b_acc), 61);  chk("t2_b3_ovf", int'(b_ovf), 1);
      chk("t2_b3_out_valid", int'(b_out_valid), 0);
      e = '{acc: 124, ovf: 1, cnt: 4}; qb.push_back(e);
      b_drive(31, 1, 1);
      chk("t2_b4_acc", int'(b_acc), 124); chk("t2_b4_ovf", int'(b_ovf), 1);
      chk("t2_b4_out_valid", int'(b_out_valid), 1);
      b_drive(0, 0, 0);
      chk("t2_hs_ovf", int'(b_ovf), 0);
      chk("t2_hs_out_valid", int'(b_out_valid), 0);
      chk("t2_hs_acc", int'(b_acc), 0);

      @(posedge clk); #1;
      chk("a_results_pending", qa.size(), 0);
      chk("b_results_pending", qb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
